multi_alarm_clock: RTL and testbench

MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

---
 rtl/clock_pkg.sv | 32 +++
 rtl/bcd_mod_counter.sv | 50 +++++
 rtl/multi_alarm_clock.sv | 207 ++++++++++++++++++++
 tb/tb_multi_alarm_clock.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module : clock_pkg
// Brief  : Shared BCD types, alarm FSM states and time helpers
// Rev    : 1.0
// ============================================================================
package clock_pkg;

  typedef logic [7:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } alarm_state_t;

  localparam bcd_t C_BCD_59 = 8'h59;
  localparam bcd_t C_BCD_23 = 8'h23;

  function automatic bcd_t bcd_from_int(input int value);
    return bcd_t'(((value / 10) * 16) + (value % 10));
  endfunction

  // Valid BCD digits are checked first so the range compares are meaningful.
  function automatic logic bcd_time_valid(input bcd_t hr, input bcd_t mn);
    return (hr[7:4] <= 4'd9) && (hr[3:0] <= 4'd9) &&
           (mn[7:4] <= 4'd9) && (mn[3:0] <= 4'd9) &&
           (hr <= C_BCD_23) && (mn <= C_BCD_59);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module : bcd_mod_counter
// Brief  : Two-digit BCD counter modulo MOD with tick enable and adjust input
// Rev    : 1.0
// ============================================================================
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       adj,
  output logic [7:0] value,
  output logic [7:0] nxt,
  output logic       carry
);

  localparam bcd_t C_LAST = bcd_from_int(MOD - 1);

  bcd_t r_value;
  bcd_t w_bumped;

  always_comb begin
    if (r_value == C_LAST) begin
      w_bumped = '0;
    end else if (r_value[3:0] == 4'd9) begin
      w_bumped = {r_value[7:4] + 4'd1, 4'd0};
    end else begin
      w_bumped = r_value + 8'd1;
    end
  end

  // A coincident adjust absorbs the tick carry: the field moves once, nothing ripples up.
  assign nxt   = (en || adj) ? w_bumped : r_value;
  assign carry = en && !adj && (r_value == C_LAST);
  assign value = r_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
    end else begin
      r_value <= nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_alarm_clock.sv
`default_nettype none
// ============================================================================
// Module : multi_alarm_clock
// Brief  : BCD 24h clock with N alarm slots, snooze, auto-off ring and chime
// Rev    : 1.0
// ============================================================================
module multi_alarm_clock
  import clock_pkg::*;
#(
  parameter int DIV        = 1000,
  parameter int N_ALM      = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60
) (
  input  logic                                       CP,
  input  logic                                       CR,
  input  logic                                       adj_min,
  input  logic                                       adj_hr,
  input  logic                                       alm_wr,
  input  logic [((N_ALM > 1) ? $clog2(N_ALM) : 1)-1:0] alm_sel,
  input  logic [7:0]                                 alm_hr,
  input  logic [7:0]                                 alm_min,
  input  logic [N_ALM-1:0]                           alm_en,
  input  logic                                       mode12,
  input  logic                                       snooze,
  input  logic                                       dismiss,
  output logic [7:0]                                 hour,
  output logic [7:0]                                 minute,
  output logic [7:0]                                 second,
  output logic [7:0]                                 disp_hr,
  output logic                                       pm,
  output logic                                       sec_tick,
  output logic                                       ringing,
  output logic [((N_ALM > 1) ? $clog2(N_ALM) : 1)-1:0] ring_id,
  output logic                                       chime
);

  localparam int              SW            = (N_ALM > 1) ? $clog2(N_ALM) : 1;
  localparam int              DW            = $clog2(DIV);
  localparam logic [DW-1:0]   C_DIV_LAST    = DW'(DIV - 1);
  localparam logic [7:0]      C_RING_LAST   = 8'(RING_SEC - 1);
  localparam logic [11:0]     C_SNOOZE_LOAD = 12'(SNOOZE_MIN * 60);

  logic [DW-1:0] r_div;
  logic          w_tick;

  always_ff @(posedge CP) begin
    if (CR || (r_div == C_DIV_LAST)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  assign w_tick   = (r_div == C_DIV_LAST);
  assign sec_tick = w_tick;

  bcd_t w_sec, w_min, w_hr, w_sec_nxt, w_min_nxt, w_hr_nxt;
  logic w_sec_carry, w_min_carry, w_unused_hr_carry;

  bcd_mod_counter #(.MOD(60)) u_sec (
    .clk(CP), .rst(CR), .en(w_tick), .adj(1'b0),
    .value(w_sec), .nxt(w_sec_nxt), .carry(w_sec_carry)
  );

  bcd_mod_counter #(.MOD(60)) u_min (
    .clk(CP), .rst(CR), .en(w_sec_carry), .adj(adj_min),
    .value(w_min), .nxt(w_min_nxt), .carry(w_min_carry)
  );

  bcd_mod_counter #(.MOD(24)) u_hr (
    .clk(CP), .rst(CR), .en(w_min_carry), .adj(adj_hr),
    .value(w_hr), .nxt(w_hr_nxt), .carry(w_unused_hr_carry)
  );

  assign hour   = w_hr;
  assign minute = w_min;
  assign second = w_sec;

  bcd_t    r_alm_hr  [N_ALM];
  bcd_t    r_alm_min [N_ALM];
  logic    w_wr_ok;

  assign w_wr_ok = alm_wr && bcd_time_valid(alm_hr, alm_min) && (int'(alm_sel) < N_ALM);

  always_ff @(posedge CP) begin
    for (int i = 0; i < N_ALM; i++) begin
      if (CR) begin
        r_alm_hr[i]  <= '0;
        r_alm_min[i] <= '0;
      end else if (w_wr_ok && (SW'(i) == alm_sel)) begin
        r_alm_hr[i]  <= alm_hr;
        r_alm_min[i] <= alm_min;
      end
    end
  end

  // Matching uses the post-edge time so the ring starts on the same edge as hh:mm:00.
  logic          w_on_minute;
  logic          w_match;
  logic [SW-1:0] w_match_id;

  assign w_on_minute = w_tick && (w_sec_nxt == 8'h00);

  always_comb begin
    w_match    = 1'b0;
    w_match_id = '0;
    for (int i = N_ALM - 1; i >= 0; i--) begin
      if (w_on_minute && alm_en[i] && (r_alm_hr[i] == w_hr_nxt) && (r_alm_min[i] == w_min_nxt)) begin
        w_match    = 1'b1;
        w_match_id = SW'(i);
      end
    end
  end

  alarm_state_t  r_state, w_state_nxt;
  logic [SW-1:0] r_ring_id, w_ring_id_nxt;
  logic [7:0]    r_ring_cnt, w_ring_cnt_nxt;
  logic [11:0]   r_snz_cnt, w_snz_cnt_nxt;
  logic          r_ringing;

  always_ff @(posedge CP) begin
    if (CR) begin
      r_state    <= ST_IDLE;
      r_ring_id  <= '0;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
      r_ringing  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ring_id  <= w_ring_id_nxt;
      r_ring_cnt <= w_ring_cnt_nxt;
      r_snz_cnt  <= w_snz_cnt_nxt;
      r_ringing  <= (w_state_nxt == ST_RING);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ring_id_nxt  = r_ring_id;
    w_ring_cnt_nxt = r_ring_cnt;
    w_snz_cnt_nxt  = r_snz_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_match) begin
          w_state_nxt    = ST_RING;
          w_ring_id_nxt  = w_match_id;
          w_ring_cnt_nxt = '0;
        end
      end
      ST_RING: begin
        if (dismiss) begin
          w_state_nxt = ST_IDLE;
        end else if (snooze) begin
          w_state_nxt   = ST_SNOOZE;
          w_snz_cnt_nxt = C_SNOOZE_LOAD;
        end else if (w_tick) begin
          if (r_ring_cnt == C_RING_LAST) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_ring_cnt_nxt = r_ring_cnt + 8'd1;
          end
        end
      end
      ST_SNOOZE: begin
        if (dismiss) begin
          w_state_nxt = ST_IDLE;
        end else if (w_match) begin
          w_state_nxt    = ST_RING;
          w_ring_id_nxt  = w_match_id;
          w_ring_cnt_nxt = '0;
        end else if (w_tick) begin
          if (r_snz_cnt <= 12'd1) begin
            w_state_nxt    = ST_RING;
            w_ring_cnt_nxt = '0;
            w_snz_cnt_nxt  = '0;
          end else begin
            w_snz_cnt_nxt = r_snz_cnt - 12'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign ringing = r_ringing;
  assign ring_id = r_ring_id;

  assign chime = (w_min == C_BCD_59) && (w_sec[7:4] == 4'h5) && w_sec[0];
  assign pm    = (w_hr >= 8'h12);

  // 13..19 subtract directly in BCD; 20..23 need a borrow across the tens digit.
  always_comb begin
    disp_hr = w_hr;
    if (mode12) begin
      if (w_hr == 8'h00) begin
        disp_hr = 8'h12;
      end else if ((w_hr[7:4] == 4'h1) && (w_hr[3:0] >= 4'h3)) begin
        disp_hr = w_hr - 8'h12;
      end else if (w_hr[7:4] == 4'h2) begin
        disp_hr = (w_hr[3:0] < 4'h2) ? {4'h0, w_hr[3:0] + 4'h8} : {4'h1, w_hr[3:0] - 4'h2};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_alarm_clock.sv
`default_nettype none
// ============================================================================
// Module : tb_multi_alarm_clock
// Brief  : Self-checking bench for multi_alarm_clock against a seconds-of-day model
// Rev    : 1.0
// ============================================================================
module tb_multi_alarm_clock;

  localparam int DIV = 4, N_ALM = 4, SNOOZE_MIN = 1, RING_SEC = 5;
  localparam int S_IDLE = 0, S_RING = 1, S_SNOOZE = 2;

  logic CP = 1'b0, CR = 1'b1, adj_min = 1'b0, adj_hr = 1'b0, alm_wr = 1'b0;
  logic [1:0] alm_sel = 2'd0;
  logic [7:0] alm_hr = 8'h00, alm_min = 8'h00;
  logic [3:0] alm_en = 4'b0000;
  logic mode12 = 1'b0, snooze = 1'b0, dismiss = 1'b0;
  logic [7:0] hour, minute, second, disp_hr;
  logic pm, sec_tick, ringing, chime;
  logic [1:0] ring_id;

  int checks = 0, errors = 0;

  int m_tod, m_div, m_state, m_id, m_ring_left, m_snz_left;
  int m_sh [N_ALM];
  int m_sm [N_ALM];
  bit m_last_tick;

  multi_alarm_clock #(.DIV(DIV), .N_ALM(N_ALM), .SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC)) dut (
    .CP(CP), .CR(CR), .adj_min(adj_min), .adj_hr(adj_hr), .alm_wr(alm_wr), .alm_sel(alm_sel),
    .alm_hr(alm_hr), .alm_min(alm_min), .alm_en(alm_en), .mode12(mode12), .snooze(snooze),
    .dismiss(dismiss), .hour(hour), .minute(minute), .second(second), .disp_hr(disp_hr), .pm(pm),
    .sec_tick(sec_tick), .ringing(ringing), .ring_id(ring_id), .chime(chime)
  );

  always #5 CP = ~CP;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int unbcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit bcd_ok(input logic [7:0] h, input logic [7:0] m);
    return (h[7:4] < 10) && (h[3:0] < 10) && (m[7:4] < 10) && (m[3:0] < 10) && (unbcd(h) < 24) && (unbcd(m) < 60);
  endfunction

  function automatic int mh(); return m_tod / 3600; endfunction
  function automatic int mm(); return (m_tod / 60) % 60; endfunction
  function automatic int ms(); return m_tod % 60; endfunction

  function automatic logic [7:0] exp_disp(input int h, input logic m12);
    if (!m12) return bcd(h);
    if (h == 0) return 8'h12;
    return (h > 12) ? bcd(h - 12) : bcd(h);
  endfunction

  // Reference: time held as seconds of day, alarm as plain state + remaining-tick counts.
  task automatic model_update();
    int h, m, s, hit;
    bit tk, cm, ch;
    m_last_tick = 1'b0;
    if (CR) begin
      m_tod = 0; m_div = 0; m_state = S_IDLE; m_id = 0; m_ring_left = 0; m_snz_left = 0;
      for (int i = 0; i < N_ALM; i++) begin m_sh[i] = 0; m_sm[i] = 0; end
      return;
    end
    tk = (m_div == DIV - 1);
    m_last_tick = tk;
    h = mh(); m = mm(); s = ms(); cm = 1'b0; ch = 1'b0;
    if (tk) begin s++; if (s == 60) begin s = 0; cm = 1'b1; end end
    if (adj_min) m = (m + 1) % 60;
    else if (cm) begin m++; if (m == 60) begin m = 0; ch = 1'b1; end end
    if (adj_hr || ch) h = (h + 1) % 24;
    m_tod = h * 3600 + m * 60 + s;
    hit = -1;
    if (tk && s == 0)
      for (int i = N_ALM - 1; i >= 0; i--)
        if (alm_en[i] && m_sh[i] == h && m_sm[i] == m) hit = i;
    case (m_state)
      S_IDLE:   if (hit >= 0) begin m_state = S_RING; m_id = hit; m_ring_left = RING_SEC; end
      S_RING: begin
        if (dismiss) m_state = S_IDLE;
        else if (snooze) begin m_state = S_SNOOZE; m_snz_left = SNOOZE_MIN * 60; end
        else if (tk) begin m_ring_left--; if (m_ring_left == 0) m_state = S_IDLE; end
      end
      default: begin
        if (dismiss) m_state = S_IDLE;
        else if (hit >= 0) begin m_state = S_RING; m_id = hit; m_ring_left = RING_SEC; end
        else if (tk) begin m_snz_left--; if (m_snz_left == 0) begin m_state = S_RING; m_ring_left = RING_SEC; end end
      end
    endcase
    if (alm_wr && bcd_ok(alm_hr, alm_min) && int'(alm_sel) < N_ALM) begin
      m_sh[alm_sel] = unbcd(alm_hr);
      m_sm[alm_sel] = unbcd(alm_min);
    end
    m_div = (m_div + 1) % DIV;
  endtask

  task automatic step();
    @(posedge CP);
    model_update();
    #1;
  endtask

  task automatic step_to_tick();
    int n = 0;
    do begin step(); n++; end while (!m_last_tick && n < 2 * DIV);
    if (!m_last_tick) begin checks++; errors++; $display("FAIL tick_timeout: got no tick within %0d cycles", n); end
  endtask

  task automatic set_time(input int th, input int tm, input int ts);
    int budget = 20000;
    while (!(mh() == th && mm() == tm && ms() == ts) && budget > 0) begin
      if (mh() != th) adj_hr = 1'b1;
      else if (mm() != tm) adj_min = 1'b1;
      step();
      adj_hr = 1'b0; adj_min = 1'b0;
      budget--;
    end
    checks++;
    if (budget == 0) begin errors++; $display("FAIL set_time: got %0d expected %0d", m_tod, th * 3600 + tm * 60 + ts); end
  endtask

  task automatic write_slot(input int sel, input logic [7:0] h, input logic [7:0] m);
    alm_sel = 2'(sel); alm_hr = h; alm_min = m; alm_wr = 1'b1;
    step();
    alm_wr = 1'b0;
  endtask

  task automatic test_reset();
    CR = 1'b1; mode12 = 1'b1;
    step(); step();
    checks += 9;
    if (hour !== 8'h00)   begin errors++; $display("FAIL reset_hour: got %h expected 00", hour); end
    if (minute !== 8'h00) begin errors++; $display("FAIL reset_minute: got %h expected 00", minute); end
    if (second !== 8'h00) begin errors++; $display("FAIL reset_second: got %h expected 00", second); end
    if (ringing !== 1'b0) begin errors++; $display("FAIL reset_ringing: got %b expected 0", ringing); end
    if (ring_id !== 2'd0) begin errors++; $display("FAIL reset_ring_id: got %0d expected 0", ring_id); end
    if (sec_tick !== 1'b0) begin errors++; $display("FAIL reset_sec_tick: got %b expected 0", sec_tick); end
    if (pm !== 1'b0)      begin errors++; $display("FAIL reset_pm: got %b expected 0", pm); end
    if (disp_hr !== 8'h12) begin errors++; $display("FAIL reset_disp12: got %h expected 12", disp_hr); end
    if (chime !== 1'b0)   begin errors++; $display("FAIL reset_chime: got %b expected 0", chime); end
    mode12 = 1'b0; #1;
    checks++;
    if (disp_hr !== 8'h00) begin errors++; $display("FAIL reset_disp24: got %h expected 00", disp_hr); end
    CR = 1'b0;
  endtask

  task automatic test_count();
    int n = 0;
    for (int i = 0; i < 240; i++) begin
      checks++;
      if (sec_tick !== (m_div == DIV - 1)) begin errors++; $display("FAIL count_tick: got %b at cycle %0d", sec_tick, i); end
      if (sec_tick) n++;
      step();
    end
    checks += 3;
    if (n != 60)          begin errors++; $display("FAIL count_pulses: got %0d expected 60", n); end
    if (second !== 8'h00) begin errors++; $display("FAIL count_second: got %h expected 00", second); end
    if (minute !== 8'h01) begin errors++; $display("FAIL count_minute: got %h expected 01", minute); end
  endtask

  task automatic test_rollover();
    set_time(23, 59, 58);
    mode12 = 1'b1; #1;
    checks += 2;
    if (disp_hr !== 8'h11) begin errors++; $display("FAIL roll_disp_23: got %h expected 11", disp_hr); end
    if (pm !== 1'b1)       begin errors++; $display("FAIL roll_pm_23: got %b expected 1", pm); end
    step_to_tick(); step_to_tick();
    checks += 5;
    if (hour !== 8'h00)    begin errors++; $display("FAIL roll_hour: got %h expected 00", hour); end
    if (minute !== 8'h00)  begin errors++; $display("FAIL roll_minute: got %h expected 00", minute); end
    if (second !== 8'h00)  begin errors++; $display("FAIL roll_second: got %h expected 00", second); end
    if (pm !== 1'b0)       begin errors++; $display("FAIL roll_pm: got %b expected 0", pm); end
    if (disp_hr !== 8'h12) begin errors++; $display("FAIL roll_disp: got %h expected 12", disp_hr); end
  endtask

  task automatic test_alarm();
    int n = 0;
    write_slot(2, 8'h07, 8'h30);
    set_time(7, 29, 59);
    alm_en = 4'b0100;
    step_to_tick();
    checks += 4;
    if ({hour, minute, second} !== 24'h073000) begin errors++; $display("FAIL alarm_time: got %h%h%h expected 073000", hour, minute, second); end
    if (ringing !== 1'b1) begin errors++; $display("FAIL alarm_ring: got %b expected 1", ringing); end
    if (ring_id !== 2'd2) begin errors++; $display("FAIL alarm_id: got %0d expected 2", ring_id); end
    if (ringing !== (m_state == S_RING)) begin errors++; $display("FAIL alarm_model: got %b expected %b", ringing, m_state == S_RING); end
    while (n < RING_SEC + 2) begin
      step_to_tick(); n++;
      if (!ringing) break;
    end
    checks++;
    if (n != RING_SEC) begin errors++; $display("FAIL alarm_autooff: got %0d ticks expected %0d", n, RING_SEC); end
  endtask

  task automatic test_snooze();
    int n = 0, rung = 0;
    set_time(7, 29, 59);
    step_to_tick();
    snooze = 1'b1; step(); snooze = 1'b0;
    checks++;
    if (ringing !== 1'b0) begin errors++; $display("FAIL snooze_off: got %b expected 0", ringing); end
    while (n < 70) begin
      step_to_tick(); n++;
      if (ringing) break;
    end
    checks += 2;
    if (n != SNOOZE_MIN * 60) begin errors++; $display("FAIL snooze_len: got %0d ticks expected %0d", n, SNOOZE_MIN * 60); end
    if (ring_id !== 2'd2)     begin errors++; $display("FAIL snooze_id: got %0d expected 2", ring_id); end
    snooze = 1'b1; dismiss = 1'b1; step(); dismiss = 1'b0;
    step(); snooze = 1'b0;
    checks++;
    if (ringing !== 1'b0) begin errors++; $display("FAIL snooze_dismiss: got %b expected 0", ringing); end
    for (int i = 0; i < 65; i++) begin step_to_tick(); if (ringing) rung++; end
    checks++;
    if (rung != 0) begin errors++; $display("FAIL snooze_residual: got %0d ringing ticks expected 0", rung); end
  endtask

  task automatic test_bad_write();
    alm_en = 4'b0000;
    write_slot(1, 8'h24, 8'h00);
    write_slot(1, 8'h1A, 8'h00);
    write_slot(1, 8'h00, 8'h60);
    set_time(23, 59, 59);
    alm_en = 4'b0010;
    step_to_tick();
    checks += 2;
    if (ringing !== 1'b1) begin errors++; $display("FAIL badwr_ring: got %b expected 1", ringing); end
    if (ring_id !== 2'd1) begin errors++; $display("FAIL badwr_id: got %0d expected 1", ring_id); end
    dismiss = 1'b1; step(); dismiss = 1'b0;
    alm_en = 4'b0000;
  endtask

  task automatic test_adj_carry();
    set_time(10, 59, 59);
    while (m_div != DIV - 1) step();
    adj_min = 1'b1; step(); adj_min = 1'b0;
    checks++;
    if ({hour, minute, second} !== 24'h100000) begin errors++; $display("FAIL adj_carry: got %h%h%h expected 100000", hour, minute, second); end
  endtask

  task automatic test_chime();
    int n = 0;
    bit e;
    set_time(10, 59, 49);
    for (int i = 0; i < 14 * DIV; i++) begin
      e = (mm() == 59) && (ms() >= 51) && (ms() % 2 == 1);
      checks++;
      if (chime !== e) begin errors++; $display("FAIL chime_level: got %b expected %b at %0d", chime, e, ms()); end
      if (chime) n++;
      step();
    end
    checks++;
    if (n != 5 * DIV) begin errors++; $display("FAIL chime_cycles: got %0d expected %0d", n, 5 * DIV); end
  endtask

  task automatic test_cr_ring();
    int rung = 0;
    write_slot(0, 8'h11, 8'h01);
    alm_en = 4'b0001;
    set_time(11, 0, 59);
    step_to_tick();
    CR = 1'b1; step(); CR = 1'b0;
    checks += 2;
    if (ringing !== 1'b0) begin errors++; $display("FAIL cr_ring: got %b expected 0", ringing); end
    if (hour !== 8'h00)   begin errors++; $display("FAIL cr_hour: got %h expected 00", hour); end
    write_slot(0, 8'h00, 8'h01);
    set_time(0, 0, 59);
    step_to_tick();
    checks++;
    if (ringing !== 1'b1) begin errors++; $display("FAIL cr_prering: got %b expected 1", ringing); end
    snooze = 1'b1; step(); snooze = 1'b0;
    CR = 1'b1; step(); CR = 1'b0;
    for (int i = 0; i < 65; i++) begin step_to_tick(); if (ringing) rung++; end
    checks++;
    if (rung != 0) begin errors++; $display("FAIL cr_snooze_residual: got %0d expected 0", rung); end
    alm_en = 4'b0000;
  endtask

  task automatic test_random();
    int tmin;
    for (int i = 0; i < 4000; i++) begin
      CR      = ($urandom_range(999) == 0);
      adj_min = ($urandom_range(99) == 0);
      adj_hr  = ($urandom_range(199) == 0);
      snooze  = ($urandom_range(59) == 0);
      dismiss = ($urandom_range(199) == 0);
      if ($urandom_range(49) == 0) mode12 = ~mode12;
      if ($urandom_range(99) == 0) alm_en = 4'($urandom);
      alm_wr = ($urandom_range(29) == 0);
      if (alm_wr) begin
        alm_sel = 2'($urandom);
        if ($urandom_range(9) < 7) begin
          tmin = (m_tod / 60 + 1 + int'($urandom_range(1))) % 1440;
          alm_hr = bcd(tmin / 60); alm_min = bcd(tmin % 60);
        end else begin
          alm_hr = 8'($urandom); alm_min = 8'($urandom);
        end
      end
      step();
      checks += 9;
      if (hour !== bcd(mh()))   begin errors++; $display("FAIL rnd_hour: got %h expected %h", hour, bcd(mh())); end
      if (minute !== bcd(mm())) begin errors++; $display("FAIL rnd_minute: got %h expected %h", minute, bcd(mm())); end
      if (second !== bcd(ms())) begin errors++; $display("FAIL rnd_second: got %h expected %h", second, bcd(ms())); end
      if (sec_tick !== (m_div == DIV - 1)) begin errors++; $display("FAIL rnd_tick: got %b expected %b", sec_tick, m_div == DIV - 1); end
      if (ringing !== (m_state == S_RING)) begin errors++; $display("FAIL rnd_ringing: got %b expected %b", ringing, m_state == S_RING); end
      if (ring_id !== 2'(m_id)) begin errors++; $display("FAIL rnd_ring_id: got %0d expected %0d", ring_id, m_id); end
      if (chime !== ((mm() == 59) && (ms() >= 51) && (ms() % 2 == 1))) begin errors++; $display("FAIL rnd_chime: got %b at %0d:%0d", chime, mm(), ms()); end
      if (pm !== (mh() >= 12)) begin errors++; $display("FAIL rnd_pm: got %b expected %b", pm, mh() >= 12); end
      if (disp_hr !== exp_disp(mh(), mode12)) begin errors++; $display("FAIL rnd_disp: got %h expected %h", disp_hr, exp_disp(mh(), mode12)); end
    end
    CR = 1'b0; adj_min = 1'b0; adj_hr = 1'b0; snooze = 1'b0; dismiss = 1'b0; alm_wr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_rollover();
    test_alarm();
    test_snooze();
    test_bad_write();
    test_adj_carry();
    test_chime();
    test_cr_ring();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
